// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: register file geometry, stall reasons, issue FSM states.
package cpu_pkg;

  localparam int unsigned NREG  = 32;
  localparam int unsigned REGW  = $clog2(NREG);
  localparam int unsigned PCNTW = 32;

  typedef enum logic [1:0] {
    RSN_NONE   = 2'd0,
    RSN_SCORE  = 2'd1,
    RSN_STRUCT = 2'd2,
    RSN_DOWN   = 2'd3
  } stall_rsn_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_hazard_chk.sv
// Per-slot match of sources/destination against the effective pending scoreboard.
module sb_hazard_chk
  import cpu_pkg::*;
(
  input  logic [NREG-1:0] pend_eff,
  input  logic [REGW-1:0] rj,
  input  logic [REGW-1:0] rk,
  input  logic [REGW-1:0] rd,
  input  logic            rdsrc,
  input  logic            we,
  output logic            hazard_c
);

  // r0 is hardwired and can never be outstanding, so it is masked out explicitly.
  always_comb begin
    hazard_c = 1'b0;
    if ((rj != '0) && pend_eff[rj]) hazard_c = 1'b1;
    if ((rk != '0) && pend_eff[rk]) hazard_c = 1'b1;
    if ((rdsrc || we) && (rd != '0) && pend_eff[rd]) hazard_c = 1'b1;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue hazard controller at ID->EXE0: long-latency scoreboard, pair checks, stall FSM.
module issue_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid0,
  input  logic             id_valid1,
  input  logic [REGW-1:0]  id_rj0,
  input  logic [REGW-1:0]  id_rj1,
  input  logic [REGW-1:0]  id_rk0,
  input  logic [REGW-1:0]  id_rk1,
  input  logic [REGW-1:0]  id_rd0,
  input  logic [REGW-1:0]  id_rd1,
  input  logic             id_rdsrc0,
  input  logic             id_rdsrc1,
  input  logic             id_we0,
  input  logic             id_we1,
  input  logic             id_long0,
  input  logic             id_long1,
  input  logic             exe_ready,
  input  logic             flush,
  input  logic             wb_valid0,
  input  logic             wb_valid1,
  input  logic [REGW-1:0]  wb_rd0,
  input  logic [REGW-1:0]  wb_rd1,
  output logic             issue0,
  output logic             issue1,
  output logic             stall,
  output logic [1:0]       stall_reason,
  output logic [NREG-1:0]  pending,
  output logic [PCNTW-1:0] stall_cycles
);

  sb_state_e        state_q, state_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [NREG-1:0]  wb_clr, sb_set, pend_eff;
  logic [PCNTW-1:0] cnt_q;
  logic             hazard0_c, hazard1_c;
  logic             pair_raw_c, pair_waw_c, both_long_c;
  logic             issue0_c, issue1_c, stall_c, pair_done_c;
  stall_rsn_e       rsn_c;

  // Completion strobes clear bits; same-cycle completions are bypassed by the forward unit.
  always_comb begin
    wb_clr = '0;
    if (wb_valid0) wb_clr[wb_rd0] = 1'b1;
    if (wb_valid1) wb_clr[wb_rd1] = 1'b1;
  end

  assign pend_eff = pending_q & ~wb_clr;

  sb_hazard_chk u_chk0 (
    .pend_eff (pend_eff),
    .rj       (id_rj0),
    .rk       (id_rk0),
    .rd       (id_rd0),
    .rdsrc    (id_rdsrc0),
    .we       (id_we0),
    .hazard_c (hazard0_c)
  );

  sb_hazard_chk u_chk1 (
    .pend_eff (pend_eff),
    .rj       (id_rj1),
    .rk       (id_rk1),
    .rd       (id_rd1),
    .rdsrc    (id_rdsrc1),
    .we       (id_we1),
    .hazard_c (hazard1_c)
  );

  // Intra-pair dependencies that the forward network cannot resolve within the pair.
  always_comb begin
    pair_raw_c = 1'b0;
    pair_waw_c = 1'b0;
    if (id_we0 && (id_rd0 != '0)) begin
      if ((id_rj1 == id_rd0) || (id_rk1 == id_rd0) || (id_rdsrc1 && (id_rd1 == id_rd0)))
        pair_raw_c = 1'b1;
      if (id_we1 && (id_rd1 == id_rd0))
        pair_waw_c = 1'b1;
    end
  end

  assign both_long_c = id_long0 & id_long1;
  assign issue0_c    = id_valid0 & ~flush & exe_ready & ~hazard0_c;
  assign issue1_c    = issue0_c & id_valid1 & ~hazard1_c & ~pair_raw_c & ~pair_waw_c & ~both_long_c;
  assign pair_done_c = issue0_c & (issue1_c | ~id_valid1);
  assign stall_c     = id_valid0 & ~flush & ~pair_done_c;

  // Stall reason: downstream backpressure first, then scoreboard, then pair structural.
  always_comb begin
    rsn_c = RSN_NONE;
    if (stall_c) begin
      if (!exe_ready)                rsn_c = RSN_DOWN;
      else if (hazard0_c || hazard1_c) rsn_c = RSN_SCORE;
      else                           rsn_c = RSN_STRUCT;
    end
  end

  // Issue FSM next-state: hold while the ID pair is only partly issued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (stall_c) state_d = ST_HOLD;
      ST_HOLD: if (flush || pair_done_c) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // New long-latency writers set their destination; set beats a same-cycle clear.
  always_comb begin
    sb_set = '0;
    if (issue0_c && id_we0 && id_long0) sb_set[id_rd0] = 1'b1;
    if (issue1_c && id_we1 && id_long1) sb_set[id_rd1] = 1'b1;
    pending_d    = (pending_q & ~wb_clr) | sb_set;
    pending_d[0] = 1'b0;
  end

  // Pending scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        cnt_q <= '0;
    else if (stall_c && (cnt_q != '1)) cnt_q <= cnt_q + PCNTW'(1);
  end

  // Combinational decisions are forced low while reset is asserted.
  assign issue0       = rstn & issue0_c;
  assign issue1       = rstn & issue1_c;
  assign stall        = rstn & stall_c;
  assign stall_reason = rstn ? rsn_c : RSN_NONE;
  assign pending      = pending_q;
  assign stall_cycles = cnt_q;

endmodule
